// File: rtl/seg7_pkg.sv
// Shared definitions for the 7-segment display reader: segment codes,
// FSM state encoding and digit-select helpers.
package seg7_pkg;

    localparam int NUM_DIGITS = 4;

    // Active-low segment codes, bit6=a ... bit0=g.
    localparam logic [6:0] SEG_0 = 7'b0000001;
    localparam logic [6:0] SEG_1 = 7'b1001111;
    localparam logic [6:0] SEG_2 = 7'b0010010;
    localparam logic [6:0] SEG_3 = 7'b0000110;
    localparam logic [6:0] SEG_4 = 7'b1001100;
    localparam logic [6:0] SEG_5 = 7'b0100100;
    localparam logic [6:0] SEG_6 = 7'b0100000;
    localparam logic [6:0] SEG_7 = 7'b0001111;
    localparam logic [6:0] SEG_8 = 7'b0000000;
    localparam logic [6:0] SEG_9 = 7'b0001100;
    localparam logic [6:0] SEG_A = 7'b0001000;
    localparam logic [6:0] SEG_B = 7'b1100000;
    localparam logic [6:0] SEG_C = 7'b0110001;
    localparam logic [6:0] SEG_D = 7'b1000010;
    localparam logic [6:0] SEG_E = 7'b0110000;
    localparam logic [6:0] SEG_F = 7'b0111000;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    // The display encoder drives this pattern for both 6 and B.
    localparam logic [6:0] SEG_AMBIG = 7'b1100000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_COUNT = 2'd1,
        ST_HELD  = 2'd2
    } state_e;

    function automatic logic is_one_hot_low(input logic [NUM_DIGITS-1:0] sel);
        logic result;
        case (sel)
            4'b1110, 4'b1101, 4'b1011, 4'b0111: result = 1'b1;
            default:                            result = 1'b0;
        endcase
        return result;
    endfunction

    function automatic logic [1:0] digit_index(input logic [NUM_DIGITS-1:0] sel);
        logic [1:0] idx;
        case (sel)
            4'b1110: idx = 2'd0;
            4'b1101: idx = 2'd1;
            4'b1011: idx = 2'd2;
            4'b0111: idx = 2'd3;
            default: idx = 2'd0;
        endcase
        return idx;
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational segment-pattern decoder: maps an active-low 7-bit pattern
// to a hex value and flags legal, blank and ambiguous patterns.
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [6:0] pattern_i,
    output logic [3:0] value_o,
    output logic       legal_o,
    output logic       blank_o,
    output logic       ambig_o
);

    always_comb begin
        value_o = 4'h0;
        legal_o = 1'b1;
        case (pattern_i)
            SEG_0:   value_o = 4'h0;
            SEG_1:   value_o = 4'h1;
            SEG_2:   value_o = 4'h2;
            SEG_3:   value_o = 4'h3;
            SEG_4:   value_o = 4'h4;
            SEG_5:   value_o = 4'h5;
            SEG_6:   value_o = 4'h6;
            SEG_7:   value_o = 4'h7;
            SEG_8:   value_o = 4'h8;
            SEG_9:   value_o = 4'h9;
            SEG_A:   value_o = 4'hA;
            SEG_B:   value_o = 4'hB;
            SEG_C:   value_o = 4'hC;
            SEG_D:   value_o = 4'hD;
            SEG_E:   value_o = 4'hE;
            SEG_F:   value_o = 4'hF;
            default: legal_o = 1'b0;
        endcase
    end

    assign blank_o = (pattern_i == SEG_BLANK);
    assign ambig_o = (pattern_i == SEG_AMBIG);

endmodule

// File: rtl/seg7_reader.sv
// Reads a multiplexed 4-digit 7-segment display: synchronizes the lines,
// waits for a stable one-hot sample, then decodes and captures the digit.
module seg7_reader
    import seg7_pkg::*;
#(
    parameter int STABLE_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [6:0]  seg_n,
    input  logic [3:0]  dig_sel_n,
    output logic [15:0] hex,
    output logic [3:0]  dig_valid,
    output logic        upd,
    output logic [1:0]  upd_idx,
    output logic        err,
    output logic        ambig
);

    localparam logic [7:0] STABLE_Q = STABLE_CYCLES[7:0];

    logic [6:0]  seg_s1_q, seg_s2_q;
    logic [3:0]  sel_s1_q, sel_s2_q;
    logic [10:0] sample;

    state_e      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [10:0] prev_q, prev_d;
    logic [15:0] hex_q, hex_d;
    logic [3:0]  valid_q, valid_d;
    logic        upd_q, upd_d;
    logic [1:0]  idx_q, idx_d;
    logic        err_q, err_d;
    logic        ambig_q, ambig_d;

    logic        capture;
    logic [1:0]  cap_idx;
    logic [3:0]  dec_value;
    logic        dec_legal, dec_blank, dec_ambig;

    // Two-flop synchronizer; resets to the idle (all lines high) level.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            seg_s1_q <= '1;
            seg_s2_q <= '1;
            sel_s1_q <= '1;
            sel_s2_q <= '1;
        end else begin
            seg_s1_q <= seg_n;
            seg_s2_q <= seg_s1_q;
            sel_s1_q <= dig_sel_n;
            sel_s2_q <= sel_s1_q;
        end
    end

    assign sample  = {seg_s2_q, sel_s2_q};
    assign cap_idx = digit_index(sel_s2_q);

    seg7_decode u_decode (
        .pattern_i (seg_s2_q),
        .value_o   (dec_value),
        .legal_o   (dec_legal),
        .blank_o   (dec_blank),
        .ambig_o   (dec_ambig)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= 8'd0;
            prev_q  <= '1;
            hex_q   <= 16'h0000;
            valid_q <= 4'b0000;
            upd_q   <= 1'b0;
            idx_q   <= 2'd0;
            err_q   <= 1'b0;
            ambig_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            prev_q  <= prev_d;
            hex_q   <= hex_d;
            valid_q <= valid_d;
            upd_q   <= upd_d;
            idx_q   <= idx_d;
            err_q   <= err_d;
            ambig_q <= ambig_d;
        end
    end

    // A capture fires once per stable run, on the sample that brings the
    // run length up to STABLE_CYCLES; a non-one-hot sample aborts everything.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        prev_d  = sample;
        capture = 1'b0;

        if (!is_one_hot_low(sel_s2_q)) begin
            state_d = ST_IDLE;
            cnt_d   = 8'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_COUNT;
                    cnt_d   = 8'd1;
                end
                ST_COUNT: begin
                    if (sample == prev_q) begin
                        cnt_d = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
                        if (cnt_d == STABLE_Q) begin
                            capture = 1'b1;
                            state_d = ST_HELD;
                        end
                    end else begin
                        cnt_d = 8'd1;
                    end
                end
                ST_HELD: begin
                    if (sample != prev_q) begin
                        state_d = ST_COUNT;
                        cnt_d   = 8'd1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = 8'd0;
                end
            endcase
        end
    end

    // Blank and illegal patterns both invalidate the digit but keep its nibble.
    always_comb begin
        hex_d   = hex_q;
        valid_d = valid_q;
        upd_d   = 1'b0;
        idx_d   = idx_q;
        err_d   = 1'b0;
        ambig_d = 1'b0;

        if (capture) begin
            upd_d = 1'b1;
            idx_d = cap_idx;
            if (dec_legal) begin
                hex_d[{cap_idx, 2'b00} +: 4] = dec_value;
                valid_d[cap_idx]             = 1'b1;
                ambig_d                      = dec_ambig;
            end else begin
                valid_d[cap_idx] = 1'b0;
                err_d            = !dec_blank;
            end
        end
    end

    assign hex       = hex_q;
    assign dig_valid = valid_q;
    assign upd       = upd_q;
    assign upd_idx   = idx_q;
    assign err       = err_q;
    assign ambig     = ambig_q;

endmodule

// File: tb/tb_seg7_reader.sv
// Testbench for seg7_reader: directed scenarios plus a randomized run,
// checked against a run-length based reference model.
module tb_seg7_reader;

    localparam int STABLE = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [6:0]  seg_n = 7'b1111111;
    logic [3:0]  dig_sel_n = 4'b1111;
    logic [15:0] hex;
    logic [3:0]  dig_valid;
    logic        upd;
    logic [1:0]  upd_idx;
    logic        err;
    logic        ambig;

    int total = 0;
    int bad = 0;

    logic [6:0] codes [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0001100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };

    // Reference model: the design sees each input two edges late; a capture
    // happens when a one-hot sample has repeated exactly STABLE times.
    logic [10:0] m_s1, m_s2, m_last;
    int          m_run;
    logic [15:0] m_hex;
    logic [3:0]  m_valid;
    logic        m_upd, m_err, m_ambig;
    logic [1:0]  m_idx;

    seg7_reader #(.STABLE_CYCLES(STABLE)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .seg_n     (seg_n),
        .dig_sel_n (dig_sel_n),
        .hex       (hex),
        .dig_valid (dig_valid),
        .upd       (upd),
        .upd_idx   (upd_idx),
        .err       (err),
        .ambig     (ambig)
    );

    always #5 clk = ~clk;

    function automatic int sel_index(input logic [3:0] sel);
        int zeros = 0;
        int id = -1;
        for (int i = 0; i < 4; i++) begin
            if (!sel[i]) begin
                zeros++;
                id = i;
            end
        end
        return (zeros == 1) ? id : -1;
    endfunction

    function automatic int code_value(input logic [6:0] p);
        int v = -1;
        for (int i = 0; i < 16; i++) begin
            if (codes[i] == p) v = i;
        end
        return v;
    endfunction

    task automatic tick();
        logic [10:0] smp;
        int d;
        int v;
        @(posedge clk);
        if (!rst_n) begin
            m_s1 = '1; m_s2 = '1; m_last = '1; m_run = 0;
            m_hex = 16'h0; m_valid = 4'b0; m_upd = 0; m_idx = 0; m_err = 0; m_ambig = 0;
        end else begin
            smp  = m_s2;
            m_s2 = m_s1;
            m_s1 = {seg_n, dig_sel_n};
            m_upd = 0; m_err = 0; m_ambig = 0;
            if (smp == m_last) m_run = (m_run < 255) ? m_run + 1 : m_run;
            else m_run = 1;
            m_last = smp;
            d = sel_index(smp[3:0]);
            if (d >= 0 && m_run == STABLE) begin
                m_upd = 1;
                m_idx = d[1:0];
                v = code_value(smp[10:4]);
                if (v >= 0) begin
                    m_hex[4*d +: 4] = v[3:0];
                    m_valid[d] = 1'b1;
                    m_ambig = (smp[10:4] == 7'b1100000);
                end else begin
                    m_valid[d] = 1'b0;
                    m_err = (smp[10:4] != 7'b1111111);
                end
            end
        end
        #1;
    endtask

    task automatic drive(input logic [6:0] s, input logic [3:0] d);
        seg_n = s;
        dig_sel_n = d;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive(7'b1111111, 4'b1111);
        tick();
        tick();
        total++; if (hex !== 16'h0000) begin bad++; $display("[TB] FAIL reset_hex got %h want 0000", hex); end
        total++; if (dig_valid !== 4'b0000) begin bad++; $display("[TB] FAIL reset_valid got %b want 0000", dig_valid); end
        total++; if (upd !== 1'b0) begin bad++; $display("[TB] FAIL reset_upd got %b want 0", upd); end
        total++; if (upd_idx !== 2'd0) begin bad++; $display("[TB] FAIL reset_idx got %0d want 0", upd_idx); end
        total++; if (err !== 1'b0) begin bad++; $display("[TB] FAIL reset_err got %b want 0", err); end
        total++; if (ambig !== 1'b0) begin bad++; $display("[TB] FAIL reset_ambig got %b want 0", ambig); end
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        drive(7'b0010010, 4'b1110);
        for (int i = 1; i <= 10; i++) begin
            tick();
            total++;
            if (upd !== (i == 2 + STABLE)) begin
                bad++; $display("[TB] FAIL basic_upd edge %0d got %b want %b", i, upd, (i == 2 + STABLE));
            end
            total++;
            if (err !== 1'b0) begin bad++; $display("[TB] FAIL basic_err edge %0d got %b want 0", i, err); end
            if (i == 2 + STABLE) begin
                total++;
                if (upd_idx !== 2'd0) begin bad++; $display("[TB] FAIL basic_idx got %0d want 0", upd_idx); end
            end
        end
        total++; if (hex[3:0] !== 4'h2) begin bad++; $display("[TB] FAIL basic_hex got %h want 2", hex[3:0]); end
        total++; if (dig_valid !== 4'b0001) begin bad++; $display("[TB] FAIL basic_valid got %b want 0001", dig_valid); end
    endtask

    task automatic test_ambig();
        int n_upd = 0;
        int n_amb = 0;
        drive(7'b1100000, 4'b0111);
        for (int i = 1; i <= 10; i++) begin
            tick();
            if (upd) n_upd++;
            if (ambig) n_amb++;
            total++;
            if (ambig !== m_ambig) begin bad++; $display("[TB] FAIL ambig_pulse edge %0d got %b want %b", i, ambig, m_ambig); end
            if (upd) begin
                total++;
                if (upd_idx !== 2'd3) begin bad++; $display("[TB] FAIL ambig_idx got %0d want 3", upd_idx); end
            end
        end
        total++; if (n_upd != 1) begin bad++; $display("[TB] FAIL ambig_upd_count got %0d want 1", n_upd); end
        total++; if (n_amb != 1) begin bad++; $display("[TB] FAIL ambig_count got %0d want 1", n_amb); end
        total++; if (hex[15:12] !== 4'hB) begin bad++; $display("[TB] FAIL ambig_hex got %h want B", hex[15:12]); end
        total++; if (dig_valid[3] !== 1'b1) begin bad++; $display("[TB] FAIL ambig_valid got %b want 1", dig_valid[3]); end
    endtask

    task automatic test_err();
        int n_err = 0;
        drive(7'b0100100, 4'b1101);
        for (int i = 0; i < 8; i++) tick();
        total++; if (hex[7:4] !== 4'h5) begin bad++; $display("[TB] FAIL err_pre_hex got %h want 5", hex[7:4]); end
        drive(7'b1010101, 4'b1101);
        for (int i = 1; i <= 10; i++) begin
            tick();
            if (err) n_err++;
            total++;
            if (err !== m_err) begin bad++; $display("[TB] FAIL err_pulse edge %0d got %b want %b", i, err, m_err); end
        end
        total++; if (n_err != 1) begin bad++; $display("[TB] FAIL err_count got %0d want 1", n_err); end
        total++; if (dig_valid[1] !== 1'b0) begin bad++; $display("[TB] FAIL err_valid got %b want 0", dig_valid[1]); end
        total++; if (hex[7:4] !== 4'h5) begin bad++; $display("[TB] FAIL err_hex got %h want 5", hex[7:4]); end
    endtask

    task automatic test_toggle();
        for (int k = 0; k < 8; k++) begin
            drive((k % 2 == 0) ? 7'b0000001 : 7'b1001111, 4'b1011);
            for (int j = 0; j < 3; j++) begin
                tick();
                total++;
                if (upd !== 1'b0) begin bad++; $display("[TB] FAIL toggle_noupd seg %0d got %b want 0", k, upd); end
            end
        end
        drive(7'b0000001, 4'b1011);
        for (int i = 1; i <= 12; i++) begin
            tick();
            total++;
            if (upd !== (i == 2 + STABLE)) begin
                bad++; $display("[TB] FAIL toggle_upd edge %0d got %b want %b", i, upd, (i == 2 + STABLE));
            end
        end
        total++; if (hex[11:8] !== 4'h0) begin bad++; $display("[TB] FAIL toggle_hex got %h want 0", hex[11:8]); end
        total++; if (dig_valid[2] !== 1'b1) begin bad++; $display("[TB] FAIL toggle_valid got %b want 1", dig_valid[2]); end
    endtask

    task automatic test_blank();
        int n_upd = 0;
        drive(7'b1111111, 4'b1011);
        for (int i = 1; i <= 10; i++) begin
            tick();
            if (upd) n_upd++;
            total++;
            if (err !== 1'b0 || ambig !== 1'b0) begin
                bad++; $display("[TB] FAIL blank_flags edge %0d got err=%b ambig=%b want 0 0", i, err, ambig);
            end
        end
        total++; if (n_upd != 1) begin bad++; $display("[TB] FAIL blank_upd_count got %0d want 1", n_upd); end
        total++; if (dig_valid[2] !== 1'b0) begin bad++; $display("[TB] FAIL blank_valid got %b want 0", dig_valid[2]); end
        total++; if (hex[11:8] !== 4'h0) begin bad++; $display("[TB] FAIL blank_hex got %h want 0", hex[11:8]); end
    endtask

    task automatic test_abort();
        logic [15:0] hex_before;
        logic [3:0]  valid_before;
        hex_before = m_hex;
        valid_before = m_valid;
        drive(7'b0001111, 4'b1110);
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if (upd !== 1'b0) begin bad++; $display("[TB] FAIL abort_upd_pre got %b want 0", upd); end
        end
        drive(7'b0001111, 4'b1100);
        for (int i = 0; i < 10; i++) begin
            tick();
            total++;
            if (upd !== 1'b0) begin bad++; $display("[TB] FAIL abort_upd got %b want 0", upd); end
        end
        total++; if (hex !== hex_before) begin bad++; $display("[TB] FAIL abort_hex got %h want %h", hex, hex_before); end
        total++; if (dig_valid !== valid_before) begin bad++; $display("[TB] FAIL abort_valid got %b want %b", dig_valid, valid_before); end
    endtask

    task automatic test_twohot_reset();
        drive(7'b0000000, 4'b1100);
        for (int i = 0; i < 20; i++) begin
            tick();
            total++;
            if (upd !== 1'b0) begin bad++; $display("[TB] FAIL twohot_upd got %b want 0", upd); end
        end
        drive(7'b0001100, 4'b1101);
        for (int i = 0; i < 4; i++) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        total++; if (hex !== 16'h0000) begin bad++; $display("[TB] FAIL midreset_hex got %h want 0000", hex); end
        total++; if (dig_valid !== 4'b0000) begin bad++; $display("[TB] FAIL midreset_valid got %b want 0000", dig_valid); end
        total++; if ({upd, err, ambig} !== 3'b000) begin bad++; $display("[TB] FAIL midreset_pulses got %b want 000", {upd, err, ambig}); end
        total++; if (upd_idx !== 2'd0) begin bad++; $display("[TB] FAIL midreset_idx got %0d want 0", upd_idx); end
        for (int i = 1; i <= 10; i++) begin
            tick();
            total++;
            if (upd !== (i == 2 + STABLE)) begin
                bad++; $display("[TB] FAIL midreset_upd edge %0d got %b want %b", i, upd, (i == 2 + STABLE));
            end
        end
        total++; if (hex[7:4] !== 4'h9) begin bad++; $display("[TB] FAIL midreset_hex_after got %h want 9", hex[7:4]); end
    endtask

    task automatic test_random();
        logic [6:0] s;
        logic [3:0] d;
        int hold;
        for (int seg_i = 0; seg_i < 300; seg_i++) begin
            if ($urandom_range(0, 9) < 8) begin
                d = 4'b1111;
                d[$urandom_range(0, 3)] = 1'b0;
            end else begin
                d = 4'($urandom);
            end
            case ($urandom_range(0, 9))
                0, 1, 2, 3, 4, 5: s = codes[$urandom_range(0, 15)];
                6:                s = 7'b1111111;
                7:                s = 7'b1100000;
                default:          s = 7'($urandom);
            endcase
            drive(s, d);
            if ($urandom_range(0, 39) == 0) rst_n = 1'b0;
            hold = $urandom_range(1, 9);
            for (int j = 0; j < hold; j++) begin
                tick();
                rst_n = 1'b1;
                total++;
                if ({upd, err, ambig} !== {m_upd, m_err, m_ambig}) begin
                    bad++; $display("[TB] FAIL rand_pulses seg %0d got %b want %b", seg_i, {upd, err, ambig}, {m_upd, m_err, m_ambig});
                end
                total++;
                if (hex !== m_hex || dig_valid !== m_valid) begin
                    bad++; $display("[TB] FAIL rand_regs seg %0d got %h/%b want %h/%b", seg_i, hex, dig_valid, m_hex, m_valid);
                end
                if (m_upd) begin
                    total++;
                    if (upd_idx !== m_idx) begin bad++; $display("[TB] FAIL rand_idx seg %0d got %0d want %0d", seg_i, upd_idx, m_idx); end
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_ambig();
        test_err();
        test_toggle();
        test_blank();
        test_abort();
        test_twohot_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
